// File: rtl/apb_irq_ctrl_pkg.sv
// Shared constants for the APB interrupt controller: register map, ID word layout, source limit.
package apb_irq_pkg;

  // Word index taken from PADDR[4:2]
  typedef enum logic [2:0] {
    REG_MASK    = 3'd0,
    REG_PENDING = 3'd1,
    REG_SET     = 3'd2,
    REG_CLEAR   = 3'd3,
    REG_ID      = 3'd4
  } reg_sel_e;

  localparam int unsigned ID_VALID_BIT = 31;
  localparam int unsigned MAX_IRQ      = 32;

endpackage

// File: rtl/apb_irq_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit of vec_i and whether any bit is set.
module irq_prio_enc #(
  parameter int WIDTH    = 8,
  parameter int ID_WIDTH = 3
) (
  input  logic [WIDTH-1:0]    vec_i,
  output logic                valid_o,
  output logic [ID_WIDTH-1:0] id_o
);

  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec_i[i] && !valid_o) begin
        valid_o = 1'b1;
        id_o    = ID_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: edge-captured pending bits, mask, lowest-index-first request to the core.
// Define APB_IRQ_CTRL_SYNC_EN to add a two-flop synchronizer on irq_src_i for asynchronous sources.
module apb_irq_ctrl
  import apb_irq_pkg::*;
#(
  parameter  int APB_ADDR_WIDTH = 12,
  parameter  int NUM_IRQ        = 8,
  localparam int ID_WIDTH       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_IRQ-1:0]        irq_src_i,
  output logic                      irq_o,
  output logic [ID_WIDTH-1:0]       irq_id_o,
  input  logic                      irq_ack_i,
  input  logic [ID_WIDTH-1:0]       irq_ack_id_i
);

  logic [NUM_IRQ-1:0]  mask_q, mask_d;
  logic [NUM_IRQ-1:0]  pend_q, pend_d;
  logic [NUM_IRQ-1:0]  src_q, src_s, rise;
  logic [NUM_IRQ-1:0]  set_w, clr_w, ack_vec, active;
  logic                irq_q;
  logic [ID_WIDTH-1:0] irq_id_q;
  logic                enc_valid;
  logic [ID_WIDTH-1:0] enc_id;
  logic                wr_en;
  reg_sel_e            reg_sel;
  logic                unused_ok;

  assign PREADY    = 1'b1;
  assign PSLVERR   = 1'b0;
  assign unused_ok = ^{PADDR, PWDATA};

`ifdef APB_IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src_i;
`endif

  assign rise    = src_s & ~src_q;
  assign wr_en   = PSEL && PENABLE && PWRITE;
  assign reg_sel = reg_sel_e'(PADDR[4:2]);
  assign active  = pend_q & mask_q;

  always_comb begin
    set_w   = '0;
    clr_w   = '0;
    ack_vec = '0;
    if (wr_en && reg_sel == REG_SET)   set_w = PWDATA[NUM_IRQ-1:0];
    if (wr_en && reg_sel == REG_CLEAR) clr_w = PWDATA[NUM_IRQ-1:0];
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      ack_vec[i] = irq_ack_i && (32'(irq_ack_id_i) == i);
    end
  end

  // Set terms are OR-ed after the clear mask so a capture always beats a clear/ack.
  assign pend_d = rise | set_w | (pend_q & ~(clr_w | ack_vec));
  assign mask_d = (wr_en && reg_sel == REG_MASK) ? PWDATA[NUM_IRQ-1:0] : mask_q;

  irq_prio_enc #(
    .WIDTH    (NUM_IRQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio_enc (
    .vec_i   (active),
    .valid_o (enc_valid),
    .id_o    (enc_id)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mask_q   <= '0;
      pend_q   <= '0;
      src_q    <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      src_q  <= src_s;
      irq_q  <= enc_valid;
      if (enc_valid) irq_id_q <= enc_id;
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (reg_sel)
        REG_MASK:    PRDATA[NUM_IRQ-1:0] = mask_q;
        REG_PENDING: PRDATA[NUM_IRQ-1:0] = pend_q;
        REG_ID: begin
          PRDATA[ID_VALID_BIT]   = enc_valid;
          PRDATA[ID_WIDTH-1:0]   = enc_id;
        end
        default: PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Scoreboard bench for apb_irq_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_apb_irq_ctrl;
  localparam int AW  = 12;
  localparam int N   = 8;
  localparam int IDW = 3;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b0;
  logic [AW-1:0]  PADDR = '0;
  logic [31:0]    PWDATA = '0;
  logic           PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0]    PRDATA;
  logic           PREADY, PSLVERR;
  logic [N-1:0]   irq_src_i = '0;
  logic           irq_o;
  logic [IDW-1:0] irq_id_o;
  logic           irq_ack_i = 1'b0;
  logic [IDW-1:0] irq_ack_id_i = '0;

  always #5 HCLK = ~HCLK;

  apb_irq_ctrl #(.APB_ADDR_WIDTH(AW), .NUM_IRQ(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .irq_src_i(irq_src_i), .irq_o(irq_o), .irq_id_o(irq_id_o),
    .irq_ack_i(irq_ack_i), .irq_ack_id_i(irq_ack_id_i)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  logic [31:0]    rd_q[$];
  logic [IDW:0]   irq_q[$];

  // next-cycle drive values
  logic           d_rst = 1'b0;
  logic [N-1:0]   d_src = '0;
  logic           d_sel = 1'b0, d_en = 1'b0, d_wr = 1'b0, d_ack = 1'b0;
  logic [AW-1:0]  d_addr = '0;
  logic [31:0]    d_data = '0;
  logic [IDW-1:0] d_ackid = '0;

  // behavioural model state
  logic [N-1:0]   m_pend = '0, m_mask = '0, m_prev = '0, m_sy1 = '0, m_sy2 = '0;
  logic           m_irq = 1'b0;
  logic [IDW-1:0] m_id = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int lowest_active();
    for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_read(input int off);
    int a;
    logic [31:0] r;
    r = '0;
    case (off)
      0: r[N-1:0] = m_mask;
      1: r[N-1:0] = m_pend;
      4: begin
        a = lowest_active();
        if (a >= 0) r = 32'h8000_0000 | 32'(a);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_sy1 = '0; m_sy2 = '0;
    m_irq = 1'b0; m_id = '0;
  endtask

  // One clock: drive, record what should be seen before the next edge, then advance the model across that edge.
  task automatic cyc();
    int off, a;
    bit acc;
    logic [N-1:0] s_in;
    @(posedge HCLK); #1;
    HRESETn = d_rst; irq_src_i = d_src; PSEL = d_sel; PENABLE = d_en; PWRITE = d_wr;
    PADDR = d_addr; PWDATA = d_data; irq_ack_i = d_ack; irq_ack_id_i = d_ackid;
    off = int'(d_addr[4:2]);
    acc = d_rst && d_sel && d_en;
    if (!d_rst) model_reset();
    irq_q.push_back({m_irq, m_id});
    if (acc && !d_wr) rd_q.push_back(model_read(off));
    if (d_rst) begin
`ifdef APB_IRQ_CTRL_SYNC_EN
      s_in = m_sy2; m_sy2 = m_sy1; m_sy1 = d_src;
`else
      s_in = d_src;
`endif
      a = lowest_active();
      for (int i = 0; i < N; i++) begin
        bit rise, setb, clrb;
        rise = s_in[i] && !m_prev[i];
        setb = acc && d_wr && off == 2 && d_data[i];
        clrb = (acc && d_wr && off == 3 && d_data[i]) || (d_ack && int'(d_ackid) == i);
        if (rise || setb) m_pend[i] = 1'b1;
        else if (clrb)    m_pend[i] = 1'b0;
      end
      if (acc && d_wr && off == 0) m_mask = d_data[N-1:0];
      m_prev = s_in;
      m_irq  = (a >= 0);
      if (a >= 0) m_id = IDW'(a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic apb(input bit wr, input logic [AW-1:0] a, input logic [31:0] dat);
    d_sel = 1'b1; d_en = 1'b0; d_wr = wr; d_addr = a; d_data = dat;
    cyc();
    d_en = 1'b1;
    cyc();
    d_sel = 1'b0; d_en = 1'b0; d_wr = 1'b0;
  endtask

  task automatic ack(input logic [IDW-1:0] id);
    d_ack = 1'b1; d_ackid = id;
    cyc();
    d_ack = 1'b0;
  endtask

  always @(negedge HCLK) begin
    if (mon_on) begin
      if (irq_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL irq_queue: got empty expected entry at %0t", $time);
      end else begin
        logic [IDW:0] e;
        e = irq_q.pop_front();
        chk("irq_o", 32'(irq_o), 32'(e[IDW]));
        chk("irq_id_o", 32'(irq_id_o), 32'(e[IDW-1:0]));
      end
      if (HRESETn && PSEL && PENABLE && !PWRITE) begin
        if (rd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL prdata_queue: got empty expected entry at %0t", $time);
        end else begin
          chk("prdata", PRDATA, rd_q.pop_front());
          chk("pready_pslverr", {30'd0, PREADY, PSLVERR}, 32'd2);
        end
      end
    end
  end

  initial begin
    int a;
    mon_on = 1'b1;
    idle(2);
    d_rst = 1'b1;
    idle(1);
    // reset state of every register, unmapped read and ignored unmapped write
    apb(0, 12'h000, '0); apb(0, 12'h004, '0); apb(0, 12'h010, '0); apb(0, 12'h014, '0);
    apb(1, 12'h018, 32'hFFFF_FFFF); apb(0, 12'h000, '0); apb(0, 12'h004, '0);

    // single pulse, then a long level: exactly one capture each time
    apb(1, 12'h000, 32'h03);
    d_src = 8'h02; cyc(); d_src = 8'h00; idle(3);
    apb(0, 12'h004, '0);
    apb(1, 12'h00C, 32'hFF);
    d_src = 8'h02; idle(10);
    apb(0, 12'h004, '0);
    apb(1, 12'h00C, 32'hFF); d_src = 8'h00; idle(2);
    apb(0, 12'h004, '0);

    // two simultaneous sources, acknowledged in priority order
    apb(1, 12'h000, 32'hFF);
    d_src = 8'h24; cyc(); d_src = 8'h00; idle(3);
    apb(0, 12'h010, '0);
    ack(3'd2); idle(2);
    ack(3'd5); idle(2);

    // rise beats a same-cycle CLEAR; masked pending is requested once unmasked
    apb(1, 12'h000, 32'h00);
    apb(1, 12'h008, 32'h08);
    d_sel = 1'b1; d_en = 1'b0; d_wr = 1'b1; d_addr = 12'h00C; d_data = 32'h08; cyc();
    d_en = 1'b1; d_src[3] = 1'b1; cyc();
    d_sel = 1'b0; d_en = 1'b0; d_wr = 1'b0; d_src[3] = 1'b0;
    apb(0, 12'h004, '0);
    apb(1, 12'h000, 32'h08); idle(2);
    apb(1, 12'h00C, 32'hFF); idle(1);

    // SET register, ack of a non-pending id, then real ack
    apb(1, 12'h000, 32'h80);
    apb(1, 12'h008, 32'h80); idle(2);
    ack(3'd6); idle(2);
    ack(3'd7); idle(2);
    apb(0, 12'h010, '0);

    // async reset while requesting; source held high through release
    apb(1, 12'h000, 32'h01); apb(1, 12'h008, 32'h01); idle(2);
    d_rst = 1'b0; d_src = 8'h01; cyc(); cyc();
    d_rst = 1'b1; cyc();
    apb(0, 12'h004, '0);
    d_src = 8'h00;

    // random traffic
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) d_src[b] = ~d_src[b];
      if ($urandom_range(0, 249) == 0) begin
        d_rst = 1'b0; cyc(); d_rst = 1'b1;
      end
      case ($urandom_range(0, 6))
        0, 1: cyc();
        2:    apb(1, AW'($urandom_range(0, 7) * 4), $urandom());
        3:    apb(0, AW'($urandom_range(0, 7) * 4), '0);
        4:    apb(1, 12'h000, $urandom());
        default: begin
          a = lowest_active();
          if (a >= 0 && $urandom_range(0, 2) != 0) ack(IDW'(a));
          else ack(IDW'($urandom_range(0, N - 1)));
        end
      endcase
    end
    idle(3);
    @(negedge HCLK); #1;
    mon_on = 1'b0;
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("irq_queue_drained", 32'(irq_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
